// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: captures a WIDTH-bit word on LOAD and presents it MSB first
// on SER_OUT, one bit per enabled falling edge of CLK_BAR, with BUSY/DONE/BIT_CNT status.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                     CLK_BAR,
    input  logic                     CLR_BAR,
    input  logic                     LOAD,
    input  logic [WIDTH-1:0]         PDATA,
    input  logic                     SHIFT_EN,
    output logic                     SER_OUT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [$clog2(WIDTH)-1:0] BIT_CNT
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             ser_next;
    logic             busy_next;
    logic             done_next;
    logic [CW-1:0]    cnt_next;
    logic             last_bit;

    assign last_bit = (BIT_CNT == CW'(WIDTH - 1));

    always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:  state_next = LOAD ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_next = (SHIFT_EN && last_bit) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_next = LOAD ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; unknown encodings fall through to idle values.
    always_comb begin
        sreg_next = '0;
        ser_next  = 1'b0;
        cnt_next  = '0;
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (LOAD) begin
                    sreg_next = PDATA;
                    ser_next  = PDATA[WIDTH-1];
                    busy_next = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!SHIFT_EN) begin
                    sreg_next = sreg;
                    ser_next  = SER_OUT;
                    cnt_next  = BIT_CNT;
                    busy_next = 1'b1;
                end else if (last_bit) begin
                    done_next = 1'b1;
                end else begin
                    // The current bit sits in sreg[WIDTH-1], so the next one is just below it.
                    sreg_next = {sreg[WIDTH-2:0], 1'b0};
                    ser_next  = sreg[WIDTH-2];
                    cnt_next  = BIT_CNT + CW'(1);
                    busy_next = 1'b1;
                end
            end
            default: begin
                sreg_next = '0;
            end
        endcase
    end

    always_ff @(negedge CLK_BAR or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            sreg    <= '0;
            SER_OUT <= 1'b0;
            BIT_CNT <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            sreg    <= sreg_next;
            SER_OUT <= ser_next;
            BIT_CNT <= cnt_next;
            BUSY    <= busy_next;
            DONE    <= done_next;
        end
    end

endmodule
